// File: rtl/fir_mac_pkg.sv
// Shared types and helpers for the time-multiplexed FIR MAC sequencer.
// Holds the state encoding, the default data width and the product scaling helper.
package fir_mac_pkg;

    localparam int DW_DEF   = 8;
    localparam int PROD_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fixed-point rescale of a sign-extended full-precision product.
    function automatic logic signed [PROD_MAX-1:0] scale_product(
        input logic signed [PROD_MAX-1:0] prod,
        input int                         frac
    );
        return prod >>> frac;
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient and result handshake bundle for fir_mac_sequencer.
// The master side is the sample source / result sink; the slave side is the sequencer.
interface fir_mac_sequencer_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [DW-1:0] coef_wdata;
    logic                 coef_err;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 busy;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
        input  in_ready, coef_err, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
        output in_ready, coef_err, out_valid, out_data, busy
    );
endinterface

// File: rtl/fir_tap_mult.sv
// Single shared tap multiplier: full-precision signed product, arithmetic
// shift by FRAC_BITS, then wrap-around truncation back to DW bits.
module fir_tap_mult
    import fir_mac_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int FRAC_BITS = 0
) (
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    output logic signed [DW-1:0] o_p
);

    logic signed [2*DW-1:0] w_prod;

    assign w_prod = i_a * i_b;
    assign o_p    = DW'(scale_product(PROD_MAX'(w_prod), FRAC_BITS));

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one sample per handshake, then one MAC step per cycle
// through a shared multiplier and DW-bit wrap-around adder; owns the coefficient table.
module fir_mac_sequencer
    import fir_mac_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int TAPS      = 4,
    parameter int FRAC_BITS = 0
) (
    input  logic              clk,
    input  logic              rst,
    fir_mac_sequencer_if.slave bus
);

    localparam int            AW       = $clog2(TAPS);
    localparam logic [AW-1:0] IDX_LAST = AW'(TAPS - 1);

    state_t               r_state;
    logic [AW-1:0]        r_idx;
    logic signed [DW-1:0] r_acc;
    logic signed [DW-1:0] r_x    [TAPS];
    logic signed [DW-1:0] r_coef [TAPS];
    logic                 r_in_ready;
    logic                 r_busy;
    logic                 r_out_valid;
    logic signed [DW-1:0] r_out_data;
    logic                 r_coef_err;

    logic                 w_accept;
    logic                 w_coef_wr;
    logic signed [DW-1:0] w_prod;
    logic signed [DW-1:0] w_sum;

    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_coef_wr = bus.coef_we & (r_state == IDLE);
    assign w_sum     = r_acc + w_prod;

    fir_tap_mult #(
        .DW        (DW),
        .FRAC_BITS (FRAC_BITS)
    ) u_mult (
        .i_a (r_x[r_idx]),
        .i_b (r_coef[r_idx]),
        .o_p (w_prod)
    );

    // Delay line and coefficient table, one register per tap.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_x[gi] <= '0;
                end else if (w_accept) begin
                    if (gi == 0) begin
                        r_x[gi] <= bus.in_data;
                    end else begin
                        r_x[gi] <= r_x[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_coef[gi] <= '0;
                end else if (w_coef_wr && (bus.coef_addr == AW'(gi))) begin
                    r_coef[gi] <= bus.coef_wdata;
                end
            end
        end
    endgenerate

    // The result is registered on the last MAC edge, so out_valid is visible
    // right after it and a ready sink frees the engine on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_coef_err  <= 1'b0;
        end else begin
            r_coef_err <= bus.coef_we & (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= w_sum;
                    if (r_idx == IDX_LAST) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sum;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.coef_err  = r_coef_err;

endmodule
